// File: rtl/full_adder_core.sv
// -----------------------------------------------------------------------------
// full_adder_core
//
// Registered ripple-carry adder. It computes {c,s} = x + y + z as an unsigned
// (WIDTH+1)-bit value and presents the result from output flops one clock after
// the sample is captured. With WIDTH=1 it is the classic single-bit full adder.
//
// Handshake: there is no ready signal. When in_valid is high on a rising edge,
// that edge captures x/y/z. s/c are loaded and out_valid is set. When in_valid is
// low on a rising edge, s/c hold their values and out_valid clears.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (release is synchronised)
//   in_valid   qualifies x/y/z on this edge
//   x, y       WIDTH-bit unsigned operands
//   z          carry-in
//   s          registered WIDTH-bit sum
//   c          registered carry-out
//   out_valid  s/c were updated by the most recent edge
// -----------------------------------------------------------------------------
module full_adder_core #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             z,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             out_valid
);

   logic [WIDTH-1:0] sum_d;
   logic             carry;
   logic             run_q;

   // Ripple chain of full-adder cells. The carry is a running variable rather
   // than a vector. This keeps the chain one block with no self-feedback.
   always_comb begin
      sum_d = '0;
      carry = z;
      for (int i = 0; i < WIDTH; i++) begin
         sum_d[i] = x[i] ^ y[i] ^ carry;
         carry    = (x[i] & y[i]) | (y[i] & carry) | (x[i] & carry);
      end
   end

   // run_q is low from reset until the first edge after rst_n rises. This
   // synchronises reset release. The first edge after release only sets run_q
   // and ignores any sample, so the first capture happens on the second edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= 1'b0;
         s         <= '0;
         c         <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (run_q) begin
            if (in_valid) begin
               s         <= sum_d;
               c         <= carry;
               out_valid <= 1'b1;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_full_adder_core.sv
// -----------------------------------------------------------------------------
// tb_full_adder_core
//
// Four adder instances (WIDTH = 1, 8, 4 and 16) share a clock and reset.
// Inputs are driven on the falling edge. Outputs are sampled 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_full_adder_core;

   logic clk;
   logic rst_n;

   // WIDTH=1 instance
   logic       v1, x1, y1, z1, s1, c1, ov1;
   // WIDTH=8 instance
   logic       v8, z8, c8, ov8;
   logic [7:0] x8, y8, s8;
   // WIDTH=4 instance
   logic       v4, z4, c4, ov4;
   logic [3:0] x4, y4, s4;
   // WIDTH=16 instance
   logic        v16, z16, c16, ov16;
   logic [15:0] x16, y16, s16;

   int n_checks;
   int n_errors;

   logic [16:0] exp_q[$];
   logic [16:0] last_exp;

   full_adder_core #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .x(x1), .y(y1), .z(z1),
      .s(s1), .c(c1), .out_valid(ov1)
   );
   full_adder_core #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .x(x8), .y(y8), .z(z8),
      .s(s8), .c(c8), .out_valid(ov8)
   );
   full_adder_core #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .x(x4), .y(y4), .z(z4),
      .s(s4), .c(c4), .out_valid(ov4)
   );
   full_adder_core #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(v16), .x(x16), .y(y16), .z(z16),
      .s(s16), .c(c16), .out_valid(ov16)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   // Truth-table stimulus for WIDTH=1: packed {s,c} indexed by {x,y,z}
   logic [1:0] tt_sc [8];
   initial begin
      tt_sc[0] = 2'b00; tt_sc[1] = 2'b10; tt_sc[2] = 2'b10; tt_sc[3] = 2'b01;
      tt_sc[4] = 2'b10; tt_sc[5] = 2'b01; tt_sc[6] = 2'b01; tt_sc[7] = 2'b11;
   end

   // ---------------- main sequence ----------------
   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      v1 = 0; x1 = 0; y1 = 0; z1 = 0;
      v8 = 0; x8 = 0; y8 = 0; z8 = 0;
      v4 = 0; x4 = 0; y4 = 0; z4 = 0;
      v16 = 0; x16 = 0; y16 = 0; z16 = 0;

      #3;
      check("rst_s1",   64'(s1),   64'd0);
      check("rst_ov1",  64'(ov1),  64'd0);
      check("rst_s8",   64'(s8),   64'd0);
      check("rst_c8",   64'(c8),   64'd0);
      check("rst_ov16", 64'(ov16), 64'd0);

      // Release reset; the first edge afterwards is only the synchroniser edge.
      @(negedge clk);
      rst_n = 1'b1;
      v1 = 1'b1;
      x1 = 1'b1; y1 = 1'b1; z1 = 1'b1;
      sample();
      check("rel_edge1_ov1", 64'(ov1), 64'd0);
      check("rel_edge1_s1",  64'(s1),  64'd0);

      // WIDTH=1 truth table, back-to-back
      for (int i = 0; i < 8; i++) begin
         logic [2:0] idx;
         logic [1:0] sc;
         idx = 3'(i);
         sc  = tt_sc[i];
         @(negedge clk);
         v1 = 1'b1;
         x1 = idx[2]; y1 = idx[1]; z1 = idx[0];
         sample();
         check($sformatf("tt%0d_s", i),  64'(s1),  64'(sc[1]));
         check($sformatf("tt%0d_c", i),  64'(c1),  64'(sc[0]));
         check($sformatf("tt%0d_ov", i), 64'(ov1), 64'd1);
      end
      @(negedge clk);
      v1 = 1'b0;

      // WIDTH=8 directed vectors
      @(negedge clk);
      v8 = 1'b1; x8 = 8'hFF; y8 = 8'h00; z8 = 1'b1;
      sample();
      check("ripple_s",  64'(s8),  64'h00);
      check("ripple_c",  64'(c8),  64'd1);
      check("ripple_ov", 64'(ov8), 64'd1);
      @(negedge clk);
      x8 = 8'hFF; y8 = 8'hFF; z8 = 1'b1;
      sample();
      check("max_s", 64'(s8), 64'hFF);
      check("max_c", 64'(c8), 64'd1);
      @(negedge clk);
      x8 = 8'h5A; y8 = 8'h35; z8 = 1'b0;
      sample();
      check("mid_s", 64'(s8), 64'h8F);
      check("mid_c", 64'(c8), 64'd0);
      @(negedge clk);
      v8 = 1'b0;

      // WIDTH=4 hold / valid
      @(negedge clk);
      v4 = 1'b1; x4 = 4'd3; y4 = 4'd4; z4 = 1'b0;
      sample();
      check("acc_s",  64'(s4),  64'd7);
      check("acc_c",  64'(c4),  64'd0);
      check("acc_ov", 64'(ov4), 64'd1);
      @(negedge clk);
      v4 = 1'b0; x4 = 4'd15; y4 = 4'd15;
      sample();
      check("hold_s",  64'(s4),  64'd7);
      check("hold_c",  64'(c4),  64'd0);
      check("hold_ov", 64'(ov4), 64'd0);
      @(negedge clk);
      x4 = 4'bxxxx; y4 = 4'bxxxx; z4 = 1'bx;
      sample();
      check("holdx_s",  64'(s4),  64'd7);
      check("holdx_c",  64'(c4),  64'd0);
      check("holdx_ov", 64'(ov4), 64'd0);

      // Asynchronous reset between edges
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_s",  64'(s4),  64'd0);
      check("arst_c",  64'(c4),  64'd0);
      check("arst_ov", 64'(ov4), 64'd0);
      v4 = 1'b1; x4 = 4'd5; y4 = 4'd6; z4 = 1'b1;
      sample();
      check("arst_held_s",  64'(s4),  64'd0);
      check("arst_held_ov", 64'(ov4), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      x4 = 4'd1; y4 = 4'd2; z4 = 1'b0;
      sample();
      check("rel1_s",  64'(s4),  64'd0);
      check("rel1_ov", 64'(ov4), 64'd0);
      sample();
      check("rel2_s",  64'(s4),  64'd3);
      check("rel2_ov", 64'(ov4), 64'd1);
      @(negedge clk);
      v4 = 1'b0;

      // WIDTH=16 random stimulus against an arithmetic model
      last_exp = '0;
      for (int n = 0; n < 1000; n++) begin
         logic acc;
         @(negedge clk);
         acc = 1'($urandom_range(0, 1));
         v16 = acc;
         x16 = 16'($urandom_range(0, 65535));
         y16 = 16'($urandom_range(0, 65535));
         z16 = 1'($urandom_range(0, 1));
         if (acc) exp_q.push_back(17'(x16) + 17'(y16) + 17'(z16));
         sample();
         if (acc) begin
            if (exp_q.size() > 0) last_exp = exp_q.pop_front();
            check("rand_ov", 64'(ov16), 64'd1);
         end else begin
            check("rand_ov", 64'(ov16), 64'd0);
         end
         check("rand_sum", 64'({c16, s16}), 64'(last_exp));
      end
      @(negedge clk);
      v16 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
